// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : ALU function codes and the result-stage entry layout
// Revision: 1.0
// ============================================================================
package alu_pkg;

   localparam int FN_ADD        = 0;
   localparam int FN_SUB        = 1;
   localparam int FN_AND        = 2;
   localparam int FN_OR         = 3;
   localparam int FN_XOR        = 4;
   localparam int FN_NOT        = 5;
   localparam int FN_NAND       = 6;
   localparam int FN_NOR        = 7;
   localparam int FN_XNOR       = 8;
   localparam int FN_LAST_LEGAL = 8;

   localparam int ALU_DATA_W = 64;
   localparam int ALU_TAG_W  = 5;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] result;
      logic [ALU_TAG_W-1:0]  rd;
      logic                  zero;
      logic                  overflow;
      logic                  cout;
      logic                  illegal;
   } alu_res_t;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// skid_buffer : 2-entry in-order valid/ready buffer, in_ready from state only
// Revision: 1.0
// ============================================================================
module skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] main_data_q, main_data_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             accept;
   logic             fire;

   assign in_ready_o  = !skid_valid_q && !rst;
   assign out_valid_o = main_valid_q;
   assign out_data_o  = main_data_q;
   assign accept      = in_valid_i && in_ready_o;
   assign fire        = main_valid_q && out_ready_i;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
         // Full: only a drain can make progress; the skid entry is older than anything upstream.
         if (fire) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (!main_valid_q || fire) begin
         main_valid_d = accept;
         if (accept) begin
            main_data_d = in_data_i;
         end
      end else if (accept) begin
         skid_data_d  = in_data_i;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// alu_result_stage : execute-to-writeback register with flags, sticky V, op count
// Revision: 1.0
// ============================================================================
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int FN_W   = 5,
   parameter int TAG_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_zero,
   input  logic              in_overflow,
   input  logic              in_cout,
   input  logic [FN_W-1:0]   in_fn,
   input  logic [TAG_W-1:0]  in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_rd,
   output logic              out_zero,
   output logic              out_overflow,
   output logic              out_cout,
   output logic              out_illegal,
   output logic              flag_z,
   output logic              flag_v,
   output logic              flag_c,
   output logic              sticky_v,
   input  logic              sticky_clr,
   output logic [CNT_W-1:0]  op_count
);

   localparam int PAY_W = DATA_W + TAG_W + 4;

   logic             accept;
   logic             illegal;
   logic             arith;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] out_pay;

   logic             flag_z_q, flag_z_d;
   logic             flag_v_q, flag_v_d;
   logic             flag_c_q, flag_c_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign illegal = in_fn > FN_W'(FN_LAST_LEGAL);
   assign arith   = in_fn <= FN_W'(FN_SUB);
   assign accept  = in_valid && in_ready;
   assign in_pay  = {in_result, in_rd, in_zero, in_overflow, in_cout, illegal};

   skid_buffer #(
      .WIDTH (PAY_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_pay),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_pay)
   );

   assign {out_result, out_rd, out_zero, out_overflow, out_cout, out_illegal} = out_pay;

   always_comb begin
      flag_z_d = flag_z_q;
      flag_v_d = flag_v_q;
      flag_c_d = flag_c_q;
      sticky_d = sticky_q;
      cnt_d    = cnt_q + CNT_W'(accept);
      if (accept && arith) begin
         flag_z_d = in_zero;
         flag_v_d = in_overflow;
         flag_c_d = in_cout;
      end else if (accept && !illegal) begin
         flag_z_d = in_zero;
      end
      // Set takes priority over a simultaneous clear.
      if (sticky_clr) begin
         sticky_d = 1'b0;
      end
      if (accept && arith && in_overflow) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_z_q <= 1'b0;
         flag_v_q <= 1'b0;
         flag_c_q <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         flag_z_q <= flag_z_d;
         flag_v_q <= flag_v_d;
         flag_c_q <= flag_c_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign flag_z   = flag_z_q;
   assign flag_v   = flag_v_q;
   assign flag_c   = flag_c_q;
   assign sticky_v = sticky_q;
   assign op_count = cnt_q;

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered execute-to-writeback stage directly downstream of the 64-bit ALU.
- Captures the ALU result, its Z/V/C flags, the function code and the destination register tag.
- Decouples the ALU from writeback through a 2-entry valid/ready skid buffer.
- Maintains the architectural flag register, a sticky overflow bit and an accepted-operation counter.

Parameters:
- DATA_W, 64, result width.
- FN_W, 5, ALU function-code width.
- TAG_W, 5, destination register tag width.
- CNT_W, 32, accepted-operation counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream ALU result valid.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  DATA_W  ALU out.
- in_zero  in  1  ALU zero flag.
- in_overflow  in  1  ALU overflow flag.
- in_cout  in  1  ALU carry-out.
- in_fn  in  FN_W  function code that produced the result.
- in_rd  in  TAG_W  destination register tag.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback consumes this cycle.
- out_result  out  DATA_W  registered result.
- out_rd  out  TAG_W  registered tag.
- out_zero, out_overflow, out_cout  out  1 each  registered per-op flags.
- out_illegal  out  1  entry had fn >= 9.
- flag_z, flag_v, flag_c  out  1 each  architectural flag register.
- sticky_v  out  1  sticky overflow.
- sticky_clr  in  1  clear sticky_v.
- op_count  out  CNT_W  accepted operations, wraps.

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Fire = out_valid & out_ready.
  - Entries leave strictly in arrival order.
- Storage: main register (drives out_*) and skid register, each with its own valid bit.
- in_ready:
  - in_ready = !skid_valid, taken from registered state only (no combinational path from out_ready).
  - in_ready = 0 while rst is high.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 if main is empty or fires in cycle N.
- State transitions, writing state as (main_valid, skid_valid):
  - EMPTY (0,0):
    - Accept: load main, go to ONE.
  - ONE (1,0):
    - Accept with fire: load main with the new entry, stay ONE.
    - Accept without fire: load skid, go to FULL.
    - Fire only: go to EMPTY.
  - FULL (1,1), in_ready = 0:
    - Fire: skid moves into main, go to ONE.
    - No fire: hold.
- out_illegal = (in_fn > 8), captured with the entry. Payload is passed through unchanged; the ALU has already forced it to 0.
- Flag register update, applied on the accept cycle and visible the next cycle:
  - fn 0 or 1: Z, V and C all load from the in_* flags.
  - fn 2..8: Z loads; V and C hold.
  - fn >= 9: no flag update.
- sticky_v:
  - Set on an accepted fn 0/1 entry with in_overflow = 1.
  - Cleared by sticky_clr.
  - Set and clear in the same cycle: set wins.
- op_count:
  - Increments by 1 on every accept, including illegal fn.
  - Wraps from all-ones to 0.
- Reset (synchronous, any cycle, including mid-transfer):
  - Both valid bits, flag_z/v/c, sticky_v and op_count go to 0.
  - out_result, out_rd, out_* flags and out_illegal go to 0.
  - Any in-flight entries are discarded.
  - In the cycle rst is high, the accept is ignored and no flag update occurs.
- out_* payload is stable while out_valid = 1 and out_ready = 0.

Decomposition:
- Shared package alu_pkg:
  - Function-code constants: FN_ADD = 0, FN_SUB = 1, FN_AND = 2, FN_OR = 3, FN_XOR = 4, FN_NOT = 5, FN_NAND = 6, FN_NOR = 7, FN_XNOR = 8, FN_LAST_LEGAL = 8.
  - Packed struct alu_res_t {result, rd, zero, overflow, cout, illegal}.
- Sub-module skid_buffer, parameterised on payload width:
  - Implements the 2-entry valid/ready buffer.
  - Top level adds the flag, sticky and counter logic.

Test Plan:
- Single add: accept in_result = 0, fn = 0, zero = 1, cout = 1, rd = 3 with out_ready = 1.
  - Next cycle: out_valid = 1, out_rd = 3, out_zero = 1.
  - flag_z = 1, flag_c = 1, op_count = 1.
- Backpressure: out_ready = 0, push results 0x11, 0x22, 0x33 on consecutive cycles.
  - in_ready drops after the second accept; 0x33 is held upstream.
  - Raise out_ready: outputs 0x11, 0x22, 0x33 in order, with no drop or duplicate.
- Flag retention: sub with overflow = 1, cout = 0, then AND with zero = 0.
  - flag_v = 1 and flag_c = 0 retained; flag_z = 0; sticky_v = 1.
  - Assert sticky_clr together with a new overflowing add: sticky_v stays 1.
- Illegal op: accept fn = 5'b11111.
  - out_illegal = 1.
  - flag_z/v/c unchanged.
  - op_count increments.
- Reset with FULL buffer: assert rst for 1 cycle.
  - Next cycle: out_valid = 0, in_ready = 1, all flags 0, op_count = 0.
- Counter wrap: preload by CNT_W = 4 build, 16 accepts -> op_count = 0.
